// File: rtl/wishbone_mem_arbiter.sv
// Two-master Wishbone arbiter with a single ownership register and a per-access watchdog.
// Grant is 1 clock after request; slave-side and master-side datapaths are combinational.
module wishbone_mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   // master 0
   input  logic        i_m0_we,
   input  logic        i_m0_stb,
   input  logic        i_m0_cyc,
   input  logic [3:0]  i_m0_sel,
   input  logic [31:0] i_m0_adr,
   input  logic [31:0] i_m0_dat,
   output logic [31:0] o_m0_dat,
   output logic        o_m0_ack,
   output logic        o_m0_int,
   // master 1
   input  logic        i_m1_we,
   input  logic        i_m1_stb,
   input  logic        i_m1_cyc,
   input  logic [3:0]  i_m1_sel,
   input  logic [31:0] i_m1_adr,
   input  logic [31:0] i_m1_dat,
   output logic [31:0] o_m1_dat,
   output logic        o_m1_ack,
   output logic        o_m1_int,
   // memory interconnect
   output logic        o_s_we,
   output logic        o_s_stb,
   output logic        o_s_cyc,
   output logic [3:0]  o_s_sel,
   output logic [31:0] o_s_adr,
   output logic [31:0] o_s_dat,
   input  logic [31:0] i_s_dat,
   input  logic        i_s_ack,
   input  logic        i_s_int,
   // status
   output logic [1:0]  o_grant,
   output logic        o_timeout
);

   localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;   // 0 = m0 served last, 1 = m1
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;

   logic          own_we, own_stb, own_cyc;
   logic [3:0]    own_sel;
   logic [31:0]   own_adr, own_dat;
   logic          active, fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   // Ownership only moves when the owner drops cyc; ties in IDLE go to the master not served last.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (i_m0_cyc && i_m1_cyc) state_d = last_q ? OWN0 : OWN1;
            else if (i_m0_cyc)        state_d = OWN0;
            else if (i_m1_cyc)        state_d = OWN1;
         end
         OWN0: if (!i_m0_cyc) state_d = i_m1_cyc ? OWN1 : IDLE;
         OWN1: if (!i_m1_cyc) state_d = i_m0_cyc ? OWN0 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      own_we  = 1'b0;
      own_stb = 1'b0;
      own_cyc = 1'b0;
      own_sel = '0;
      own_adr = '0;
      own_dat = '0;
      case (state_q)
         OWN0: begin
            own_we  = i_m0_we;
            own_stb = i_m0_stb;
            own_cyc = i_m0_cyc;
            own_sel = i_m0_sel;
            own_adr = i_m0_adr;
            own_dat = i_m0_dat;
         end
         OWN1: begin
            own_we  = i_m1_we;
            own_stb = i_m1_stb;
            own_cyc = i_m1_cyc;
            own_sel = i_m1_sel;
            own_adr = i_m1_adr;
            own_dat = i_m1_dat;
         end
         default: ;
      endcase
   end

   // A slave ack in the terminal cycle wins over the watchdog.
   always_comb begin
      active = own_stb && own_cyc;
      fire   = active && !i_s_ack && (cnt_q == TO_C);
      cnt_d  = '0;
      if (active && !i_s_ack && !fire && (state_d == state_q))
         cnt_d = cnt_q + CW'(1);
      tmo_d  = tmo_q || fire;
      last_d = last_q;
      if (state_d == OWN0)      last_d = 1'b0;
      else if (state_d == OWN1) last_d = 1'b1;
   end

   always_comb begin
      o_s_we   = own_we;
      o_s_stb  = own_stb && !fire;
      o_s_cyc  = own_cyc;
      o_s_sel  = own_sel;
      o_s_adr  = own_adr;
      o_s_dat  = own_dat;

      o_m0_ack = 1'b0;
      o_m0_dat = '0;
      o_m1_ack = 1'b0;
      o_m1_dat = '0;
      if (!rst && state_q == OWN0) begin
         o_m0_ack = i_s_ack || fire;
         o_m0_dat = fire ? 32'h0 : i_s_dat;
      end
      if (!rst && state_q == OWN1) begin
         o_m1_ack = i_s_ack || fire;
         o_m1_dat = fire ? 32'h0 : i_s_dat;
      end

      o_m0_int  = i_s_int;
      o_m1_int  = i_s_int;
      o_grant   = {state_q == OWN1, state_q == OWN0};
      o_timeout = tmo_q;
   end

endmodule

// File: tb/tb_wishbone_mem_arbiter.sv
// Directed bench for wishbone_mem_arbiter with TIMEOUT = 4.
module tb_wishbone_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_m0_we, i_m0_stb, i_m0_cyc;
   logic [3:0]  i_m0_sel;
   logic [31:0] i_m0_adr, i_m0_dat;
   logic [31:0] o_m0_dat;
   logic        o_m0_ack, o_m0_int;
   logic        i_m1_we, i_m1_stb, i_m1_cyc;
   logic [3:0]  i_m1_sel;
   logic [31:0] i_m1_adr, i_m1_dat;
   logic [31:0] o_m1_dat;
   logic        o_m1_ack, o_m1_int;
   logic        o_s_we, o_s_stb, o_s_cyc;
   logic [3:0]  o_s_sel;
   logic [31:0] o_s_adr, o_s_dat;
   logic [31:0] i_s_dat;
   logic        i_s_ack, i_s_int;
   logic [1:0]  o_grant;
   logic        o_timeout;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   wishbone_mem_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .i_m0_we(i_m0_we), .i_m0_stb(i_m0_stb), .i_m0_cyc(i_m0_cyc),
      .i_m0_sel(i_m0_sel), .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat),
      .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_int(o_m0_int),
      .i_m1_we(i_m1_we), .i_m1_stb(i_m1_stb), .i_m1_cyc(i_m1_cyc),
      .i_m1_sel(i_m1_sel), .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat),
      .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_int(o_m1_int),
      .o_s_we(o_s_we), .o_s_stb(o_s_stb), .o_s_cyc(o_s_cyc),
      .o_s_sel(o_s_sel), .o_s_adr(o_s_adr), .o_s_dat(o_s_dat),
      .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .i_s_int(i_s_int),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      {i_m0_we, i_m0_stb, i_m0_cyc, i_m1_we, i_m1_stb, i_m1_cyc} = '0;
      i_m0_sel = '0; i_m0_adr = '0; i_m0_dat = '0;
      i_m1_sel = '0; i_m1_adr = '0; i_m1_dat = '0;
      i_s_dat = 32'h1234_5678; i_s_ack = 1'b0; i_s_int = 1'b0;
      nx(); nx();
      @(negedge clk);
      chk("rst_grant", 32'(o_grant), 32'd0);
      chk("rst_m0_dat", o_m0_dat, 32'd0);
      chk("rst_timeout", 32'(o_timeout), 32'd0);
      rst = 1'b0;
      nx();

      // simultaneous request, then direct handoff
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_adr = 32'h0000_1000;
      i_m1_cyc = 1; i_m1_stb = 1; i_m1_adr = 32'h0000_2000;
      @(negedge clk);
      chk("idle_no_cyc", 32'(o_s_cyc), 32'd0);
      nx();
      @(negedge clk);
      chk("tie_grant_m0", 32'(o_grant), 32'd1);
      chk("tie_adr_m0", o_s_adr, 32'h0000_1000);
      nx();
      i_m0_cyc = 0; i_m0_stb = 0;
      nx();
      @(negedge clk);
      chk("handoff_grant", 32'(o_grant), 32'd2);
      chk("handoff_adr", o_s_adr, 32'h0000_2000);
      i_m1_cyc = 0; i_m1_stb = 0;
      nx();

      // m0 holds cyc over three acked writes while m1 requests
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_we = 1; i_m0_sel = 4'hC;
      i_m1_cyc = 1; i_m1_stb = 1;
      nx();
      for (int k = 0; k < 3; k++) begin
         i_m0_adr = 32'h100 + 32'(k); i_m0_dat = 32'hD000 + 32'(k);
         i_s_ack = 1; i_s_dat = 32'hBEE0 + 32'(k);
         @(negedge clk);
         chk("hold_grant", 32'(o_grant), 32'd1);
         chk("hold_m0_ack", 32'(o_m0_ack), 32'd1);
         chk("hold_m0_dat", o_m0_dat, 32'hBEE0 + 32'(k));
         chk("hold_m1_ack", 32'(o_m1_ack), 32'd0);
         chk("hold_m1_dat", o_m1_dat, 32'd0);
         chk("hold_s_dat", o_s_dat, 32'hD000 + 32'(k));
         nx();
      end
      @(negedge clk);
      chk("hold_s_sel", 32'(o_s_sel), 32'hC);
      chk("hold_s_we", 32'(o_s_we), 32'd1);
      i_s_ack = 0; i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0;
      nx();
      @(negedge clk);
      chk("hold_then_m1", 32'(o_grant), 32'd2);
      i_m1_cyc = 0; i_m1_stb = 0;
      nx();

      // ack arrives exactly when the counter hits TIMEOUT
      i_m0_cyc = 1; i_m0_stb = 1;
      nx();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("race_no_ack", 32'(o_m0_ack), 32'd0);
         nx();
      end
      i_s_ack = 1; i_s_dat = 32'hA5A5_0001;
      @(negedge clk);
      chk("race_ack", 32'(o_m0_ack), 32'd1);
      chk("race_dat", o_m0_dat, 32'hA5A5_0001);
      chk("race_stb", 32'(o_s_stb), 32'd1);
      nx();
      i_s_ack = 0;
      @(negedge clk);
      chk("race_no_timeout", 32'(o_timeout), 32'd0);
      i_m0_cyc = 0; i_m0_stb = 0;
      nx();

      // slave never acks: watchdog terminates on the 5th strobe cycle
      i_m0_cyc = 1; i_m0_stb = 1; i_s_dat = 32'hDEAD_BEEF;
      nx();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("wd_wait", 32'(o_m0_ack), 32'd0);
         nx();
      end
      @(negedge clk);
      chk("wd_ack", 32'(o_m0_ack), 32'd1);
      chk("wd_dat", o_m0_dat, 32'd0);
      chk("wd_stb", 32'(o_s_stb), 32'd0);
      nx();
      @(negedge clk);
      chk("wd_flag", 32'(o_timeout), 32'd1);
      chk("wd_one_pulse", 32'(o_m0_ack), 32'd0);
      i_m0_cyc = 0; i_m0_stb = 0;
      nx();
      @(negedge clk);
      chk("wd_sticky", 32'(o_timeout), 32'd1);

      // m0 served last, so a tie now goes to m1
      i_m0_cyc = 1; i_m1_cyc = 1;
      nx();
      @(negedge clk);
      chk("fair_grant_m1", 32'(o_grant), 32'd2);
      i_m0_cyc = 0; i_m1_cyc = 0;
      nx();
      nx();

      // reset mid m1 write
      i_m1_cyc = 1; i_m1_stb = 1; i_m1_we = 1; i_m1_adr = 32'h0000_3000;
      nx();
      @(negedge clk);
      chk("m1_write_grant", 32'(o_grant), 32'd2);
      rst = 1; i_s_ack = 1; i_s_dat = 32'h5555_AAAA;
      @(negedge clk);
      chk("rst_hi_m1_dat", o_m1_dat, 32'd0);
      nx();
      @(negedge clk);
      chk("post_rst_cyc", 32'(o_s_cyc), 32'd0);
      chk("post_rst_grant", 32'(o_grant), 32'd0);
      chk("post_rst_ack", 32'(o_m1_ack), 32'd0);
      chk("post_rst_tmo", 32'(o_timeout), 32'd0);
      rst = 0; i_s_ack = 0; i_m1_we = 0;
      i_m0_cyc = 1; i_m0_stb = 1;
      nx();
      @(negedge clk);
      chk("post_rst_tie", 32'(o_grant), 32'd1);

      // interrupt passes through in OWN0, OWN1 and IDLE
      i_s_int = 1;
      @(negedge clk);
      chk("int_own0_m0", 32'(o_m0_int), 32'd1);
      chk("int_own0_m1", 32'(o_m1_int), 32'd1);
      i_m0_cyc = 0; i_m0_stb = 0;
      nx();
      i_s_int = 0;
      @(negedge clk);
      chk("int_own1_grant", 32'(o_grant), 32'd2);
      chk("int_own1_m0", 32'(o_m0_int), 32'd0);
      i_s_int = 1;
      @(negedge clk);
      chk("int_own1_m1", 32'(o_m1_int), 32'd1);
      i_m1_cyc = 0; i_m1_stb = 0;
      nx();
      i_s_int = 0;
      @(negedge clk);
      chk("int_idle_grant", 32'(o_grant), 32'd0);
      chk("int_idle_m1", 32'(o_m1_int), 32'd0);
      i_s_int = 1;
      @(negedge clk);
      chk("int_idle_m0", 32'(o_m0_int), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
